// File: rtl/param_sync_fifo_if.sv
// param_sync_fifo_if: producer/consumer handshake bundle for param_sync_fifo.
//   master : drives wr_en/data_in/rd_en, observes data and status
//   slave  : the FIFO side, drives data_out and all status outputs
`timescale 1ns/1ps
interface param_sync_fifo_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic                  wr_en;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  full;
    logic                  empty;
    logic                  almost_full;
    logic                  almost_empty;
    logic [CW-1:0]         count;
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr_en, data_in, rd_en,
        input  data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_en, data_in, rd_en,
        output data_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/param_sync_fifo.sv
// param_sync_fifo: single-clock FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, overflow/underflow pulses and an
// optional first-word-fall-through read port.
//   clk : clock, all state changes on the rising edge
//   rst : asynchronous active-high reset
//   bus : param_sync_fifo_if.slave (wr_en/data_in/rd_en in; data_out,
//         full, empty, almost_full, almost_empty, count, overflow,
//         underflow out)
`timescale 1ns/1ps
module param_sync_fifo #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned AF_LEVEL   = DEPTH - 2,
    parameter int unsigned AE_LEVEL   = 2,
    parameter bit          FWFT       = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    param_sync_fifo_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wp_q;
    logic [AW-1:0]         rp_q;
    logic [CW-1:0]         count_q;
    logic [CW-1:0]         count_nxt;
    logic                  full_q;
    logic                  empty_q;
    logic                  af_q;
    logic                  ae_q;
    logic                  ov_q;
    logic                  un_q;
    logic                  wa_c;
    logic                  ra_c;

    // Accept decisions; a full FIFO still takes a write when a read frees a slot
    always_comb begin
        ra_c      = bus.rd_en && !empty_q;
        wa_c      = bus.wr_en && (!full_q || ra_c);
        count_nxt = count_q;
        if (wa_c && !ra_c) begin
            count_nxt = count_q + CW'(1);
        end else if (ra_c && !wa_c) begin
            count_nxt = count_q - CW'(1);
        end
    end

    // Pointers, occupancy and status flags, all derived from next-state count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            af_q    <= 1'b0;
            ae_q    <= 1'b1;
            ov_q    <= 1'b0;
            un_q    <= 1'b0;
        end else begin
            if (wa_c) begin
                wp_q <= wp_q + AW'(1);
            end
            if (ra_c) begin
                rp_q <= rp_q + AW'(1);
            end
            count_q <= count_nxt;
            full_q  <= (count_nxt == CW'(DEPTH));
            empty_q <= (count_nxt == '0);
            af_q    <= (count_nxt >= CW'(AF_LEVEL));
            ae_q    <= (count_nxt <= CW'(AE_LEVEL));
            ov_q    <= bus.wr_en && !wa_c;
            un_q    <= bus.rd_en && empty_q;
        end
    end

    // Storage array; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wa_c) begin
            mem[wp_q] <= bus.data_in;
        end
    end

    // Read port: head word shown directly in FWFT, registered on pop otherwise
    generate
        if (FWFT) begin : g_fwft
            assign bus.data_out = mem[rp_q];
        end else begin : g_std
            logic [DATA_WIDTH-1:0] dout_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    dout_q <= '0;
                end else if (ra_c) begin
                    dout_q <= mem[rp_q];
                end
            end
            assign bus.data_out = dout_q;
        end
    endgenerate

    assign bus.count        = count_q;
    assign bus.full         = full_q;
    assign bus.empty        = empty_q;
    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
    assign bus.overflow     = ov_q;
    assign bus.underflow    = un_q;
endmodule

// File: tb/tb_param_sync_fifo.sv
// tb_param_sync_fifo: directed bench for param_sync_fifo with one
// standard-mode and one FWFT instance (DEPTH=8, AF=6, AE=2, 8-bit data).
`timescale 1ns/1ps
module tb_param_sync_fifo;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    param_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) s_if ();
    param_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(8)) f_if ();

    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b0))
        u_std (.clk(clk), .rst(rst), .bus(s_if));
    param_sync_fifo #(.DATA_WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(1'b1))
        u_fwft (.clk(clk), .rst(rst), .bus(f_if));

    typedef struct {
        logic       wr;
        logic [7:0] din;
        logic       rd;
        logic [3:0] cnt;
        logic       emp;
        logic       ful;
        logic       ae;
        logic       af;
        logic       ov;
        logic       un;
        logic       chk_d;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk4(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic push(input logic wr, input logic [7:0] din, input logic rd,
                        input logic [3:0] cnt, input logic emp, input logic ful,
                        input logic ae, input logic af, input logic ov, input logic un,
                        input logic chk_d, input logic [7:0] dout);
        vec_t v;
        v.wr = wr; v.din = din; v.rd = rd; v.cnt = cnt; v.emp = emp; v.ful = ful;
        v.ae = ae; v.af = af; v.ov = ov; v.un = un; v.chk_d = chk_d; v.dout = dout;
        vecs.push_back(v);
    endtask

    // One clock of stimulus on the standard instance, sampled 1ns after the edge
    task automatic step_s(input logic wr, input logic [7:0] d, input logic rd);
        @(negedge clk);
        s_if.wr_en = wr; s_if.data_in = d; s_if.rd_en = rd;
        @(posedge clk);
        #1;
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b0;
    endtask

    task automatic step_f(input logic wr, input logic [7:0] d, input logic rd);
        @(negedge clk);
        f_if.wr_en = wr; f_if.data_in = d; f_if.rd_en = rd;
        @(posedge clk);
        #1;
        f_if.wr_en = 1'b0; f_if.rd_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] d;
        s_if.wr_en = 1'b0; s_if.rd_en = 1'b0; s_if.data_in = '0;
        f_if.wr_en = 1'b0; f_if.rd_en = 1'b0; f_if.data_in = '0;

        // wr din rd | cnt emp ful ae af ov un | chk_d dout
        push(1, 8'h01, 0, 4'd1, 0, 0, 1, 0, 0, 0, 1, 8'h00);
        push(1, 8'h02, 0, 4'd2, 0, 0, 1, 0, 0, 0, 1, 8'h00);
        push(1, 8'h03, 0, 4'd3, 0, 0, 0, 0, 0, 0, 1, 8'h00);
        push(1, 8'h04, 0, 4'd4, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        push(1, 8'h05, 0, 4'd5, 0, 0, 0, 0, 0, 0, 0, 8'h00);
        push(1, 8'h06, 0, 4'd6, 0, 0, 0, 1, 0, 0, 0, 8'h00);
        push(1, 8'h07, 0, 4'd7, 0, 0, 0, 1, 0, 0, 0, 8'h00);
        push(1, 8'h08, 0, 4'd8, 0, 1, 0, 1, 0, 0, 0, 8'h00);
        push(1, 8'h09, 0, 4'd8, 0, 1, 0, 1, 1, 0, 0, 8'h00);
        push(0, 8'h00, 0, 4'd8, 0, 1, 0, 1, 0, 0, 1, 8'h00);
        push(0, 8'h00, 1, 4'd7, 0, 0, 0, 1, 0, 0, 1, 8'h01);
        push(0, 8'h00, 1, 4'd6, 0, 0, 0, 1, 0, 0, 1, 8'h02);
        push(0, 8'h00, 1, 4'd5, 0, 0, 0, 0, 0, 0, 1, 8'h03);
        push(0, 8'h00, 1, 4'd4, 0, 0, 0, 0, 0, 0, 1, 8'h04);
        push(0, 8'h00, 1, 4'd3, 0, 0, 0, 0, 0, 0, 1, 8'h05);
        push(0, 8'h00, 1, 4'd2, 0, 0, 1, 0, 0, 0, 1, 8'h06);
        push(0, 8'h00, 1, 4'd1, 0, 0, 1, 0, 0, 0, 1, 8'h07);
        push(0, 8'h00, 1, 4'd0, 1, 0, 1, 0, 0, 0, 1, 8'h08);
        push(0, 8'h00, 1, 4'd0, 1, 0, 1, 0, 0, 1, 1, 8'h08);
        push(0, 8'h00, 0, 4'd0, 1, 0, 1, 0, 0, 0, 1, 8'h08);

        // Reset state
        @(posedge clk); @(posedge clk); #1;
        chk4("rst count", s_if.count, 4'd0);
        chk1("rst empty", s_if.empty, 1'b1);
        chk1("rst almost_empty", s_if.almost_empty, 1'b1);
        chk1("rst full", s_if.full, 1'b0);
        chk1("rst almost_full", s_if.almost_full, 1'b0);
        chk8("rst data_out", s_if.data_out, 8'h00);
        chk1("rst overflow", s_if.overflow, 1'b0);
        chk1("rst underflow", s_if.underflow, 1'b0);
        @(negedge clk); rst = 1'b0;
        step_s(0, 8'h00, 0);
        chk4("idle count", s_if.count, 4'd0);
        chk1("idle empty", s_if.empty, 1'b1);

        // Table: fill, overflow, drain, underflow
        foreach (vecs[i]) begin
            step_s(vecs[i].wr, vecs[i].din, vecs[i].rd);
            chk4($sformatf("v%0d count", i), s_if.count, vecs[i].cnt);
            chk1($sformatf("v%0d empty", i), s_if.empty, vecs[i].emp);
            chk1($sformatf("v%0d full", i), s_if.full, vecs[i].ful);
            chk1($sformatf("v%0d almost_empty", i), s_if.almost_empty, vecs[i].ae);
            chk1($sformatf("v%0d almost_full", i), s_if.almost_full, vecs[i].af);
            chk1($sformatf("v%0d overflow", i), s_if.overflow, vecs[i].ov);
            chk1($sformatf("v%0d underflow", i), s_if.underflow, vecs[i].un);
            if (vecs[i].chk_d)
                chk8($sformatf("v%0d data_out", i), s_if.data_out, vecs[i].dout);
        end

        // Full with simultaneous write/read of 0xAA
        for (int i = 0; i < 8; i++) step_s(1, 8'(8'h10 + i), 0);
        chk1("fill full", s_if.full, 1'b1);
        step_s(1, 8'hAA, 1);
        chk1("full rw overflow", s_if.overflow, 1'b0);
        chk4("full rw count", s_if.count, 4'd8);
        chk8("full rw data_out", s_if.data_out, 8'h10);
        for (int i = 1; i < 8; i++) begin
            step_s(0, 8'h00, 1);
            chk8($sformatf("drain %0d", i), s_if.data_out, 8'(8'h10 + i));
        end
        step_s(0, 8'h00, 1);
        chk8("drain last AA", s_if.data_out, 8'hAA);
        chk1("drain empty", s_if.empty, 1'b1);

        // Empty with simultaneous write/read of 0x55
        step_s(1, 8'h55, 1);
        chk1("empty rw underflow", s_if.underflow, 1'b1);
        chk4("empty rw count", s_if.count, 4'd1);
        chk8("empty rw data_out held", s_if.data_out, 8'hAA);
        step_s(0, 8'h00, 1);
        chk8("empty rw read 55", s_if.data_out, 8'h55);
        chk4("empty rw count after", s_if.count, 4'd0);
        chk1("empty rw underflow clear", s_if.underflow, 1'b0);

        // FWFT: fill with 0xF0.., then check head word before each pop
        for (int i = 0; i < 8; i++) begin
            step_f(1, 8'(8'hF0 + i), 0);
            if (i == 0) begin
                chk8("fwft first head", f_if.data_out, 8'hF0);
                chk1("fwft first empty", f_if.empty, 1'b0);
            end
        end
        chk1("fwft full", f_if.full, 1'b1);
        for (int i = 0; i < 8; i++) begin
            chk8($sformatf("fwft head %0d", i), f_if.data_out, 8'(8'hF0 + i));
            step_f(0, 8'h00, 1);
        end
        chk1("fwft drained empty", f_if.empty, 1'b1);
        step_f(1, 8'h3C, 0);
        chk8("fwft 3C data_out", f_if.data_out, 8'h3C);
        chk1("fwft 3C empty", f_if.empty, 1'b0);
        chk4("fwft 3C count", f_if.count, 4'd1);
        step_f(0, 8'h00, 1);
        chk1("fwft pop empty", f_if.empty, 1'b1);
        chk8("fwft pop data_out", f_if.data_out, 8'hF1);
        step_f(0, 8'h00, 1);
        chk1("fwft underflow", f_if.underflow, 1'b1);
        chk8("fwft underflow data_out", f_if.data_out, 8'hF1);
        chk4("fwft underflow count", f_if.count, 4'd0);
        step_f(1, 8'h77, 1);
        chk1("fwft empty rw underflow", f_if.underflow, 1'b1);
        chk4("fwft empty rw count", f_if.count, 4'd1);
        chk8("fwft empty rw data_out", f_if.data_out, 8'h77);
        step_f(0, 8'h00, 1);
        chk4("fwft empty rw drained", f_if.count, 4'd0);

        // Wrap: interleaved write/read pairs, occupancy never above 1
        for (int i = 0; i < 20; i++) begin
            d = 8'($urandom_range(0, 255));
            step_s(1, d, 0);
            chk4($sformatf("wrap %0d count", i), s_if.count, 4'd1);
            step_s(0, 8'h00, 1);
            chk8($sformatf("wrap %0d data", i), s_if.data_out, d);
            chk4($sformatf("wrap %0d count0", i), s_if.count, 4'd0);
        end
        step_s(1, 8'hFF, 0);
        step_s(0, 8'h00, 1);
        chk8("pre-reset data_out", s_if.data_out, 8'hFF);

        // Asynchronous reset mid-fill at count=5
        for (int i = 0; i < 5; i++) step_s(1, 8'(8'h20 + i), 0);
        chk4("midfill count", s_if.count, 4'd5);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk4("async rst count", s_if.count, 4'd0);
        chk1("async rst empty", s_if.empty, 1'b1);
        chk1("async rst almost_empty", s_if.almost_empty, 1'b1);
        chk1("async rst full", s_if.full, 1'b0);
        chk1("async rst almost_full", s_if.almost_full, 1'b0);
        chk8("async rst data_out", s_if.data_out, 8'h00);
        @(negedge clk); rst = 1'b0;
        step_s(1, 8'h99, 0);
        chk4("post-rst count", s_if.count, 4'd1);
        step_s(0, 8'h00, 1);
        chk8("post-rst data", s_if.data_out, 8'h99);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/param_sync_fifo.md
# param_sync_fifo

Parameterised single-clock FIFO: the next-generation buffer for the verification/data-path environment, with width and depth generics. Adds programmable almost-full/almost-empty thresholds, an occupancy count, overflow/underflow error pulses, and a selectable first-word-fall-through (FWFT) read mode. It sits between any producer and consumer sharing `clk`, and is driven and sampled at `posedge clk` by the team's FIFO driver and monitor.

## Interface
- `DATA_WIDTH`, 8, word width in bits (≥1)
- `DEPTH`, 8, number of entries; power of two, ≥2
- `AF_LEVEL`, DEPTH-2, `almost_full` asserts when count ≥ AF_LEVEL (1..DEPTH)
- `AE_LEVEL`, 2, `almost_empty` asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- `FWFT`, 0, 0 = standard registered read; 1 = first-word-fall-through

- `clk` input 1, single clock; all state changes on rising edge
- `rst` input 1, asynchronous, active-high reset
- `wr_en` input 1, write request
- `data_in` input DATA_WIDTH, write data
- `rd_en` input 1, read request
- `data_out` output DATA_WIDTH, read data
- `full` output 1, count == DEPTH
- `empty` output 1, count == 0
- `almost_full` output 1, count ≥ AF_LEVEL
- `almost_empty` output 1, count ≤ AE_LEVEL
- `count` output $clog2(DEPTH)+1, current occupancy 0..DEPTH
- `overflow` output 1, one-cycle pulse: write rejected
- `underflow` output 1, one-cycle pulse: read rejected

## Operation
- Storage: DEPTH×DATA_WIDTH register array. Write pointer `wp` and read pointer `rp` are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. `count` is tracked in its own register (it is not derived from the pointers).
- Write accepted (`wa`) = `wr_en` && (!full || `ra`). When accepted: mem[wp] ← data_in, wp increments.
- Read accepted (`ra`) = `rd_en` && !empty. When accepted: rp increments.
- Count update: +1 on wa only, -1 on ra only, unchanged on both or neither.
- Full with wr_en and rd_en together: both are accepted, count stays DEPTH, no overflow.
- Empty with wr_en and rd_en together: the write is accepted, the read is rejected, count becomes 1, and underflow pulses. This applies in both modes.
- `overflow` registers (wr_en && !wa). `underflow` registers (rd_en && empty). Each is high for exactly the cycle after the offending edge.
- Standard mode (FWFT=0): on ra, data_out ← mem[rp] at the same edge. Otherwise data_out holds its last value.
- FWFT mode (FWFT=1): data_out = mem[rp] combinationally. It is valid whenever !empty and is undefined-but-stable (last array content) when empty. rd_en pops the displayed word.
- Flags and count are all registers, computed from the next-state count. No output is a combinational function of wr_en/rd_en.
- Reset values: wp=rp=0, count=0, empty=1, almost_empty=1 (since AE_LEVEL ≥ 0), full=0, almost_full=0, overflow=0, underflow=0, data_out=0 (standard mode). Array contents are not reset.
- Reset asserted mid-operation clears all of the above immediately (asynchronous). Any in-flight write is lost. First accept is possible on the first rising edge after rst deasserts.

## Timing
- Write-to-flag latency is 1 edge: a write accepted at edge N shows in count/empty/full after edge N.
- Standard mode read latency: data_out is valid after the edge that accepted rd_en.
- FWFT read latency: a word written at edge N appears on data_out after edge N, with empty=0.
- Throughput: one write and one read per cycle sustained, at any occupancy.
- Pointer wrap: no bubble or extra latency at DEPTH-1→0.
- Inputs are sampled at posedge clk. Outputs are stable within a clock-to-q delay, so a 1-unit input/output skew clocking block samples them cleanly.

## Test plan
- Reset, then idle: count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0. Pulse rst mid-fill at count=5 → all of these return to their reset values asynchronously.
- DEPTH=8, AF=6, AE=2, standard mode. Write 0x01..0x08 → almost_empty drops after the 3rd write, almost_full rises after the 6th, full after the 8th. A 9th write → overflow pulses for 1 cycle and count stays 8. Then read 8 → data_out is 0x01..0x08, each one cycle after its rd_en.
- Full plus simultaneous wr_en/rd_en with data 0xAA → no overflow, count=8, and 0xAA is read last after draining.
- Empty plus simultaneous wr_en/rd_en with data 0x55 → underflow pulses, count=1, and the next read returns 0x55.
- FWFT=1: write 0x3C to an empty FIFO → data_out=0x3C and empty=0 the cycle after. rd_en → empty=1. A read while empty → underflow, and data_out is unchanged.
- Wrap: 20 interleaved write/read pairs with random data → the scoreboard matches order, and count never exceeds 1.
